sig_debounce: RTL and testbench

Input conditioning stage placed directly upstream of the signal-transition detector. It synchronises an asynchronous raw input (pushbutton, external strobe) into the `clk` domain and debounces it. It drives a clean, glitch-free level `d_clean` that feeds the transition detector's `d` input, so the detector's rise, fall and toggle pulses fire once per real transition.

---
 rtl/sig_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/sig_debounce.sv | 126 ++++++++++++
 tb/tb_sig_debounce.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// Shared types and constants for the sig_debounce input-conditioning stage.
package sig_pkg;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } deb_state_t;

    localparam int GLITCH_CNT_W    = 8;
    localparam int DEFAULT_CNT_MAX = 1000;

    // Saturating increment so the reject counter parks at its maximum.
    function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
        logic [GLITCH_CNT_W-1:0] r;
        if (v == {GLITCH_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + GLITCH_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to RESET_LEVEL.
module sync_2ff #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Metastability chain: only s2 is consumed downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= RESET_LEVEL;
            s2_q <= RESET_LEVEL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/sig_debounce.sv
// Synchronises and debounces a raw asynchronous input into a clean level.
// Optional reject counter enabled by SIG_DEBOUNCE_GLITCH_CNT_EN.
module sig_debounce
    import sig_pkg::*;
#(
    parameter int   CNT_MAX     = DEFAULT_CNT_MAX,
    parameter int   CNT_W       = $clog2(CNT_MAX),
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_raw,
    output logic d_clean,
    output logic busy
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             s2_s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_clean_q, d_clean_d;
    logic             busy_q, busy_d;
    logic             accept_s;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic                    reject_s;
    logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;
`endif

    sync_2ff #(
        .RESET_LEVEL(RESET_LEVEL)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (d_raw),
        .q_o    (s2_s)
    );

    // State register: FSM, counter and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= STABLE;
            cnt_q     <= {CNT_W{1'b0}};
            d_clean_q <= RESET_LEVEL;
            busy_q    <= 1'b0;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
            glitch_q  <= {GLITCH_CNT_W{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_clean_q <= d_clean_d;
            busy_q    <= busy_d;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
            glitch_q  <= glitch_d;
`endif
        end
    end

    // Next-state logic; the bounce check is tested before the terminal count so it wins a tie.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        reject_s = 1'b0;
`endif
        case (state_q)
            STABLE: begin
                if (s2_s != d_clean_q) begin
                    state_d = QUALIFY;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            QUALIFY: begin
                if (s2_s == d_clean_q) begin
                    state_d  = STABLE;
                    cnt_d    = {CNT_W{1'b0}};
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
                    reject_s = 1'b1;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = STABLE;
                    cnt_d    = {CNT_W{1'b0}};
                    accept_s = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        busy_d = (state_d == QUALIFY);
        if (accept_s) begin
            d_clean_d = s2_s;
        end else begin
            d_clean_d = d_clean_q;
        end
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        if (reject_s) begin
            glitch_d = sat_inc(glitch_q);
        end else begin
            glitch_d = glitch_q;
        end
`endif
    end

    assign d_clean = d_clean_q;
    assign busy    = busy_q;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sig_debounce.sv
// Directed self-checking bench for sig_debounce with CNT_MAX = 4, RESET_LEVEL = 0.
module tb_sig_debounce;
    import sig_pkg::*;

    localparam int CNT_MAX = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic d_raw;
    logic d_clean;
    logic busy;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_cnt;
    int exp_glitch = 0;
`endif

    int checks   = 0;
    int failures = 0;

    sig_debounce #(
        .CNT_MAX    (CNT_MAX),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .d_raw  (d_raw),
        .d_clean(d_clean),
        .busy   (busy)
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_glitch(input int add, input string tag);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        logic [GLITCH_CNT_W-1:0] e;
        exp_glitch = exp_glitch + add;
        e = (exp_glitch > 255) ? 8'd255 : 8'(exp_glitch);
        checks++;
        assert (glitch_cnt === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, glitch_cnt, e);
        end
`endif
    endtask

    // Step d_raw to lvl and hold; edge k of the loop is edge k after first capture.
    task automatic step_level(input logic lvl, input string tag);
        d_raw = lvl;
        for (int k = 0; k <= 6; k++) begin
            tick();
            chk({tag, "_dclean"}, d_clean, (k >= 5) ? lvl : ~lvl);
            chk({tag, "_busy"}, busy, (k >= 2 && k <= 4));
        end
    endtask

    initial begin
        // 1. Reset with d_raw high, then release and watch the rise.
        reset_n = 1'b0;
        d_raw   = 1'b1;
        tick();
        tick();
        chk("rst_dclean", d_clean, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk_glitch(0, "rst_glitch");
        reset_n = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            chk("rst_rise_dclean", d_clean, (k >= 5));
            chk("rst_rise_busy", busy, (k >= 2 && k <= 4));
        end

        // 6. Clean fall.
        step_level(1'b0, "fall1");

        // 3a. Three-cycle pulse is rejected (same-edge tie goes to reject).
        d_raw = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k == 3) d_raw = 1'b0;
            tick();
            chk("glitch3_dclean", d_clean, 1'b0);
            chk("glitch3_busy", busy, (k >= 2 && k <= 4));
        end
        chk_glitch(1, "glitch3_cnt");

        // 3b. Four-cycle pulse is accepted, then falls CNT_MAX edges later.
        d_raw = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k == 4) d_raw = 1'b0;
            tick();
            chk("pulse4_dclean", d_clean, (k >= 5 && k <= 8));
            chk("pulse4_busy", busy, (k >= 2 && k <= 4) || (k >= 6 && k <= 8));
        end
        chk_glitch(0, "pulse4_cnt");

        // 4. Bounce burst 1,0,1,0,1 then hold high: two aborts, one rise.
        for (int k = 0; k <= 12; k++) begin
            d_raw = (k >= 4) ? 1'b1 : ((k % 2) == 0);
            tick();
            chk("bounce_dclean", d_clean, (k >= 9));
            chk("bounce_busy", busy, (k == 2) || (k == 4) || (k >= 6 && k <= 8));
        end
        chk_glitch(2, "bounce_cnt");

        // 6. Clean fall again so d_clean matches the reset level.
        step_level(1'b0, "fall2");

        // 5a. 300 one-cycle glitches saturate the reject counter.
        for (int i = 0; i < 300; i++) begin
            d_raw = 1'b1;
            tick();
            d_raw = 1'b0;
            tick();
            tick();
            tick();
        end
        chk("sat_dclean", d_clean, 1'b0);
        chk_glitch(300, "sat_cnt");

        // 5b. Reset while qualifying a rise: cleared asynchronously, no output change.
        d_raw = 1'b1;
        tick();
        tick();
        tick();
        chk("midq_busy_pre", busy, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midq_busy_rst", busy, 1'b0);
        chk("midq_dclean_rst", d_clean, 1'b0);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        exp_glitch = 0;
`endif
        chk_glitch(0, "midq_glitch_rst");
        d_raw = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("midq_post_dclean", d_clean, 1'b0);
            chk("midq_post_busy", busy, 1'b0);
        end

        // 2. Clean rise after reset.
        step_level(1'b1, "rise");
        chk_glitch(0, "final_cnt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
